// File: rtl/boot_loader_pkg.sv
// boot_loader_pkg: shared state/error encodings and END_WORD width fitting for the boot loader
package boot_loader_pkg;

  localparam int unsigned MAX_DW = 256;

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, DONE, ERROR} state_e;

  typedef enum logic [1:0] {ERR_NONE, ERR_OVERRUN, ERR_OVERFLOW, ERR_TIMEOUT} err_code_e;

  // Zero-extends or truncates the terminator to the memory word width (caller casts to dw bits).
  function automatic logic [MAX_DW-1:0] end_word_fit(input logic [MAX_DW-1:0] w, input int unsigned dw);
    return w & ((MAX_DW'(1) << dw) - MAX_DW'(1));
  endfunction

endpackage

// File: rtl/boot_byte_packer.sv
// boot_byte_packer: assembles little-endian words from a byte strobe and flags inter-byte timeouts
module boot_byte_packer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [7:0]            byte_i,
  input  logic                  active_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  timeout_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned CW = $clog2(NB);
  localparam int unsigned TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  last, wait_tmo;

  // Bytes shift in from the top, so after NB bytes byte 0 sits in the low lane.
  assign last         = cnt_q == CW'(NB - 1);
  assign word_valid_o = en_i && last;
  assign word_o       = {byte_i, data_q[DATA_WIDTH-1:8]};
  assign wait_tmo     = active_i && !en_i && cnt_q != '0;
  assign timeout_o    = (TIMEOUT_CYC != 0) && wait_tmo && tmo_q == TW'(TIMEOUT_CYC - 1);

  // Next-state for byte position, shift register and idle counter.
  always_comb begin
    cnt_d  = en_i ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    data_d = en_i ? word_o : data_q;
    tmo_d  = wait_tmo ? tmo_q + 1'b1 : '0;
  end

  // Packer state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      data_q <= '0;
      tmo_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      tmo_q  <= tmo_d;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: selects a byte source, packs words and streams them into instruction memory
module boot_loader_ctrl import boot_loader_pkg::*; #(
  parameter int unsigned        DATA_WIDTH  = 32,
  parameter int unsigned        ADDR_WIDTH  = 12,
  parameter int unsigned        NUM_SRC     = 2,
  parameter int unsigned        SRC_SEL_W   = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1,
  parameter logic [MAX_DW-1:0]  END_WORD    = 'h0000_0FFF,
  parameter int unsigned        TIMEOUT_CYC = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [SRC_SEL_W-1:0]  src_sel_i,
  input  logic [NUM_SRC-1:0]    byte_valid_i,
  input  logic [NUM_SRC*8-1:0]  byte_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  output logic                  sys_rst_req_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [ADDR_WIDTH:0]   word_count_o,
  output logic [DATA_WIDTH-1:0] checksum_o
);

  localparam logic [DATA_WIDTH-1:0] END_W = DATA_WIDTH'(end_word_fit(END_WORD, DATA_WIDTH));

  state_e                state_q, state_d;
  err_code_e             err_q, err_d;
  logic [SRC_SEL_W-1:0]  sel_q, sel_d, sel_in, sel;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, csum_q, csum_d, word;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d, nxt;
  logic                  acc, grant, word_valid, tmo, ld;

  // Out-of-range selects fall back to source 0; the select only tracks the input while IDLE.
  assign sel_in = (32'(src_sel_i) < NUM_SRC) ? src_sel_i : '0;
  assign sel    = state_q == IDLE ? sel_in : sel_q;
  assign acc    = byte_valid_i[sel] && (state_q == IDLE || state_q == LOAD);
  assign grant  = we_q && mem_gnt_i;
  // Granted words equal the next free address, so one counter serves both.
  assign nxt    = cnt_q + (ADDR_WIDTH + 1)'(grant);
  assign ld     = state_q == LOAD && word_valid && word != END_W;

  boot_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_packer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (acc),
    .byte_i      (byte_i[8*sel +: 8]),
    .active_i    (state_q == LOAD),
    .word_valid_o(word_valid),
    .word_o      (word),
    .timeout_o   (tmo)
  );

  // FSM next-state, write buffer and bookkeeping; errors override grant-driven buffer updates.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    sel_d   = sel;
    we_d    = we_q && !grant;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = nxt;
    csum_d  = grant ? csum_q ^ wdata_q : csum_q;
    if (state_q == IDLE && acc) state_d = LOAD;
    else if (state_q == LOAD && tmo) begin
      state_d = ERROR;
      err_d   = ERR_TIMEOUT;
    end else if (state_q == LOAD && word_valid && word == END_W) state_d = (we_q && !grant) ? DRAIN : DONE;
    else if (ld && nxt[ADDR_WIDTH]) begin
      state_d = ERROR;
      err_d   = ERR_OVERFLOW;
    end else if (ld && we_q && !grant) begin
      state_d = ERROR;
      err_d   = ERR_OVERRUN;
    end else if (ld) begin
      we_d    = 1'b1;
      addr_d  = nxt[ADDR_WIDTH-1:0];
      wdata_d = word;
    end else if (state_q == DRAIN && grant) state_d = DONE;
    if (state_d == ERROR) we_d = 1'b0;
  end

  // Controller state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      err_q   <= ERR_NONE;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  assign mem_we_o      = we_q;
  assign mem_addr_o    = addr_q;
  assign mem_wdata_o   = wdata_q;
  assign sys_rst_req_o = state_q != DONE;
  assign done_o        = state_q == DONE;
  assign err_o         = state_q == ERROR;
  assign err_code_o    = err_q;
  assign word_count_o  = cnt_q;
  assign checksum_o    = csum_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: randomized scenario checks of boot_loader_ctrl against a word-level model
module tb_boot_loader_ctrl;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int NS = 2;
  localparam int TO = 100;
  localparam logic [DW-1:0] END_W = 32'h0000_0FFF;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [0:0]      src_sel = '0;
  logic [NS-1:0]   bv = '0;
  logic [NS*8-1:0] bb = '0;
  logic            gnt = 1'b0;
  logic            mem_we, sys_rst, done, err;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, csum;
  logic [1:0]      err_code;
  logic [AW:0]     wcnt;

  int vec = 0;
  int bad = 0;

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t wq[$];

  boot_loader_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_SRC    (NS),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .src_sel_i    (src_sel),
    .byte_valid_i (bv),
    .byte_i       (bb),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (gnt),
    .sys_rst_req_o(sys_rst),
    .done_o       (done),
    .err_o        (err),
    .err_code_o   (err_code),
    .word_count_o (wcnt),
    .checksum_o   (csum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && mem_we && gnt) wq.push_back({mem_addr, mem_wdata});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input bit noise);
    int o;
    o = 1 - s;
    bv = '0;
    bv[s] = 1'b1;
    bb[8*s +: 8] = b;
    if (noise && $urandom_range(1) == 1) begin
      bv[o] = 1'b1;
      bb[8*o +: 8] = 8'($urandom);
    end
    tick();
    bv = '0;
  endtask

  task automatic send_word(input int s, input logic [DW-1:0] w, input bit noise, input int gap, input int igap);
    for (int i = 0; i < DW / 8; i++) begin
      send_byte(s, w[8*i +: 8], noise);
      if (i < DW / 8 - 1) repeat ($urandom_range(igap)) tick();
    end
    repeat (gap) tick();
  endtask

  task automatic do_reset();
    bv = '0;
    gnt = 1'b0;
    #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wq.delete();
    tick();
  endtask

  task automatic test_reset();
    logic [74:0] rexp, ract;
    rexp = '0;
    rexp[39] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    ract = {mem_we, mem_addr, mem_wdata, sys_rst, done, err, err_code, wcnt, csum};
    vec++;
    if (ract !== rexp) begin bad++; $display("FAIL reset_values got %h want %h", ract, rexp); end
    tick();
    rst_n = 1'b1;
    tick();
    wq.delete();
  endtask

  task automatic test_basic();
    do_reset();
    src_sel = 1'b1;
    gnt = 1'b1;
    tick();
    send_word(1, 32'h1234_5678, 0, 0, 0);
    send_word(1, END_W, 0, 3, 0);
    vec++;
    if (wq.size() != 1) begin bad++; $display("FAIL basic_nwrites got %0d want 1", wq.size()); end
    else begin
      vec++;
      if (wq[0] !== {2'd0, 32'h1234_5678}) begin bad++; $display("FAIL basic_write got %h want %h", wq[0], {2'd0, 32'h1234_5678}); end
    end
    vec++;
    if ({done, sys_rst, err} !== 3'b100) begin bad++; $display("FAIL basic_status got %b want 100", {done, sys_rst, err}); end
    vec++;
    if (wcnt !== 3'd1 || csum !== 32'h1234_5678) begin bad++; $display("FAIL basic_count got %0d/%h want 1/12345678", wcnt, csum); end
  endtask

  task automatic test_wrong_src();
    do_reset();
    src_sel = 1'b1;
    gnt = 1'b1;
    tick();
    send_word(0, 32'h1234_5678, 0, 0, 0);
    send_word(0, END_W, 0, 3, 0);
    vec++;
    if (wq.size() != 0 || {sys_rst, done, err} !== 3'b100) begin
      bad++;
      $display("FAIL wrong_src got writes=%0d st=%b want 0/100", wq.size(), {sys_rst, done, err});
    end
    send_word(1, END_W, 0, 2, 0);
    vec++;
    if (done !== 1'b1 || wcnt !== 3'd0) begin bad++; $display("FAIL wrong_src_after got done=%b cnt=%0d want 1/0", done, wcnt); end
  endtask

  task automatic test_random();
    logic [DW-1:0] words[5];
    logic [DW-1:0] xs;
    int n, s, en;
    for (int it = 0; it < 10; it++) begin
      do_reset();
      s = $urandom_range(1);
      src_sel = 1'(s);
      gnt = 1'b1;
      tick();
      n = $urandom_range(5);
      for (int i = 0; i < n; i++) begin
        words[i] = $urandom;
        if (words[i] == END_W) words[i] ^= 32'h1;
        send_word(s, words[i], 1, $urandom_range(60), 90);
      end
      send_word(s, END_W, 1, 4, 20);
      en = n > 4 ? 4 : n;
      xs = '0;
      for (int i = 0; i < en; i++) xs ^= words[i];
      vec++;
      if (wq.size() != en) begin bad++; $display("FAIL rand_nwrites it=%0d got %0d want %0d", it, wq.size(), en); end
      else for (int i = 0; i < en; i++) begin
        vec++;
        if (wq[i] !== {2'(i), words[i]}) begin bad++; $display("FAIL rand_write it=%0d i=%0d got %h want %h", it, i, wq[i], {2'(i), words[i]}); end
      end
      vec++;
      if (wcnt !== 3'(en) || csum !== xs) begin bad++; $display("FAIL rand_count it=%0d got %0d/%h want %0d/%h", it, wcnt, csum, en, xs); end
      vec++;
      if ({done, sys_rst, err, err_code} !== (n > 4 ? 5'b01110 : 5'b10000)) begin
        bad++;
        $display("FAIL rand_status it=%0d n=%0d got %b want %b", it, n, {done, sys_rst, err, err_code}, (n > 4 ? 5'b01110 : 5'b10000));
      end
    end
  endtask

  task automatic test_overrun();
    do_reset();
    src_sel = 1'b0;
    tick();
    send_word(0, 32'hCAFE_0001, 0, 0, 0);
    vec++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 2'd0, 32'hCAFE_0001}) begin
      bad++;
      $display("FAIL overrun_pending got %h want %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 2'd0, 32'hCAFE_0001});
    end
    send_word(0, 32'hCAFE_0002, 0, 0, 0);
    vec++;
    if ({err, err_code, mem_we, sys_rst} !== 5'b10101 || wcnt !== 3'd0 || wq.size() != 0) begin
      bad++;
      $display("FAIL overrun_err got %b cnt=%0d w=%0d want 10101/0/0", {err, err_code, mem_we, sys_rst}, wcnt, wq.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a, b;
    a = $urandom;
    b = $urandom;
    if (a == END_W) a ^= 32'h1;
    if (b == END_W) b ^= 32'h1;
    do_reset();
    src_sel = 1'b0;
    tick();
    send_word(0, a, 0, 1, 0);
    for (int i = 0; i < 3; i++) send_byte(0, b[8*i +: 8], 0);
    gnt = 1'b1;
    send_byte(0, b[31:24], 0);
    vec++;
    if ({err, mem_we, mem_addr, mem_wdata} !== {2'b01, 2'd1, b} || wcnt !== 3'd1) begin
      bad++;
      $display("FAIL b2b_second got %h cnt=%0d want %h cnt=1", {err, mem_we, mem_addr, mem_wdata}, wcnt, {2'b01, 2'd1, b});
    end
    tick();
    vec++;
    if (mem_we !== 1'b0 || wcnt !== 3'd2 || csum !== (a ^ b)) begin
      bad++;
      $display("FAIL b2b_grant got we=%b cnt=%0d csum=%h want 0/2/%h", mem_we, wcnt, csum, a ^ b);
    end
    vec++;
    if (wq.size() != 2 || wq[0] !== {2'd0, a} || wq[1] !== {2'd1, b}) begin
      bad++;
      $display("FAIL b2b_writes got n=%0d want 2 (%h,%h)", wq.size(), {2'd0, a}, {2'd1, b});
    end
  endtask

  task automatic test_timeout();
    bit early;
    do_reset();
    repeat (1000) tick();
    vec++;
    if ({err, sys_rst} !== 2'b01) begin bad++; $display("FAIL idle_no_timeout got %b want 01", {err, sys_rst}); end
    gnt = 1'b1;
    send_word(0, 32'h0BAD_F00D, 0, 300, 0);
    vec++;
    if (err !== 1'b0) begin bad++; $display("FAIL wordgap_no_timeout got err=%b want 0", err); end
    do_reset();
    src_sel = 1'b0;
    gnt = 1'b1;
    tick();
    send_byte(0, 8'($urandom), 0);
    send_byte(0, 8'($urandom), 0);
    early = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (err !== 1'b0) early = 1'b1;
    end
    vec++;
    if (early) begin bad++; $display("FAIL timeout_early got err before %0d cycles want none", TO); end
    tick();
    vec++;
    if ({err, err_code, sys_rst} !== 4'b1111) begin bad++; $display("FAIL timeout_fire got %b want 1111", {err, err_code, sys_rst}); end
  endtask

  task automatic test_reset_mid();
    logic [74:0] rexp, ract;
    rexp = '0;
    rexp[39] = 1'b1;
    do_reset();
    src_sel = 1'b0;
    tick();
    send_word(0, 32'h5555_AAAA, 0, 0, 0);
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    #2 rst_n = 1'b0;
    #1;
    ract = {mem_we, mem_addr, mem_wdata, sys_rst, done, err, err_code, wcnt, csum};
    vec++;
    if (ract !== rexp) begin bad++; $display("FAIL reset_mid got %h want %h", ract, rexp); end
    tick();
    rst_n = 1'b1;
    wq.delete();
    gnt = 1'b1;
    tick();
    send_word(0, END_W, 0, 2, 0);
    vec++;
    if (done !== 1'b1 || wcnt !== 3'd0 || wq.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_restart got done=%b cnt=%0d w=%0d want 1/0/0", done, wcnt, wq.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrong_src();
    test_random();
    test_overrun();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
